// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | riscv_ctrl_pkg : state codes, opcodes and mux encodings shared by the  |
// | multicycle RISC-V controller.           Revision 1.0                  |
// +-----------------------------------------------------------------------+
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECUTEI = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic       ADR_PC      = 1'b0;
   localparam logic       ADR_RESULT  = 1'b1;

   localparam logic [1:0] SRC_A_PC    = 2'b00;
   localparam logic [1:0] SRC_A_OLDPC = 2'b01;
   localparam logic [1:0] SRC_A_REG   = 2'b10;

   localparam logic [1:0] SRC_B_REG   = 2'b00;
   localparam logic [1:0] SRC_B_IMM   = 2'b01;
   localparam logic [1:0] SRC_B_FOUR  = 2'b10;

   localparam logic [1:0] RES_ALUOUT  = 2'b00;
   localparam logic [1:0] RES_DATA    = 2'b01;
   localparam logic [1:0] RES_ALU     = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] IMM_I       = 2'b00;
   localparam logic [1:0] IMM_S       = 2'b01;
   localparam logic [1:0] IMM_B       = 2'b10;
   localparam logic [1:0] IMM_J       = 2'b11;

   // Outputs that depend only on the state; held in a register.
   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       adr_src;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
   } moore_ctrl_t;

   localparam moore_ctrl_t MOORE_IDLE = '0;

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | multicycle_controller_if : controller <-> datapath signal bundle.     |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
interface multicycle_controller_if #(
   parameter int width = 7
);
   logic [width-1:0] opcode;
   logic             zero;
   logic             mem_ready;

   logic             pc_write;
   logic             adr_src;
   logic             ir_write;
   logic             mem_read;
   logic             mem_write;
   logic             reg_write;
   logic             stall;
   logic [1:0]       result_src;
   logic [1:0]       alu_src_a;
   logic [1:0]       alu_src_b;
   logic [1:0]       imm_src;
   logic [1:0]       alu_op;
   logic [3:0]       state;

   modport master (
      input  opcode, zero, mem_ready,
      output pc_write, adr_src, ir_write, mem_read, mem_write, reg_write, stall,
      output result_src, alu_src_a, alu_src_b, imm_src, alu_op, state
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  pc_write, adr_src, ir_write, mem_read, mem_write, reg_write, stall,
      input  result_src, alu_src_a, alu_src_b, imm_src, alu_op, state
   );
endinterface
`default_nettype wire

// File: rtl/imm_src_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | imm_src_decoder : opcode -> immediate-format select, combinational.   |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module imm_src_decoder
   import riscv_ctrl_pkg::*;
#(
   parameter int width = 7
) (
   input  logic [width-1:0] opcode,
   output logic [1:0]       imm_src
);

   always_comb begin
      imm_src = IMM_I;
      case (opcode)
         width'(OP_STORE):  imm_src = IMM_S;
         width'(OP_BRANCH): imm_src = IMM_B;
         width'(OP_JAL):    imm_src = IMM_J;
         default:           imm_src = IMM_I;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | multicycle_controller : RISC-V multicycle control FSM with memory     |
// | wait-state handling.                    Revision 1.0                  |
// +-----------------------------------------------------------------------+
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter int width = 7
) (
   input  logic                     clk,
   input  logic                     rst,
   multicycle_controller_if.master  bus
);

   state_t           state_q;
   state_t           state_d;
   moore_ctrl_t      moore_q;
   moore_ctrl_t      moore_out;
   logic [width-1:0] opcode;
   logic [1:0]       imm_src;
   logic             wait_access;

   assign opcode = bus.opcode;

   imm_src_decoder #(.width(width)) u_imm_src_decoder (
      .opcode  (opcode),
      .imm_src (imm_src)
   );

   function automatic moore_ctrl_t moore_of(input state_t s);
      moore_ctrl_t m;
      m = MOORE_IDLE;
      case (s)
         S_FETCH: begin
            m.mem_read   = 1'b1;
            m.adr_src    = ADR_PC;
            m.alu_src_a  = SRC_A_PC;
            m.alu_src_b  = SRC_B_FOUR;
            m.alu_op     = ALUOP_ADD;
            m.result_src = RES_ALU;
         end
         S_DECODE: begin
            m.alu_src_a  = SRC_A_OLDPC;
            m.alu_src_b  = SRC_B_IMM;
            m.alu_op     = ALUOP_ADD;
         end
         S_MEMADR: begin
            m.alu_src_a  = SRC_A_REG;
            m.alu_src_b  = SRC_B_IMM;
            m.alu_op     = ALUOP_ADD;
         end
         S_MEMREAD: begin
            m.mem_read   = 1'b1;
            m.adr_src    = ADR_RESULT;
            m.result_src = RES_ALUOUT;
         end
         S_MEMWB: begin
            m.result_src = RES_DATA;
            m.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            m.mem_write  = 1'b1;
            m.adr_src    = ADR_RESULT;
            m.result_src = RES_ALUOUT;
         end
         S_EXECUTER: begin
            m.alu_src_a  = SRC_A_REG;
            m.alu_src_b  = SRC_B_REG;
            m.alu_op     = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            m.alu_src_a  = SRC_A_REG;
            m.alu_src_b  = SRC_B_IMM;
            m.alu_op     = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            m.result_src = RES_ALUOUT;
            m.reg_write  = 1'b1;
         end
         S_BEQ: begin
            m.alu_src_a  = SRC_A_REG;
            m.alu_src_b  = SRC_B_REG;
            m.alu_op     = ALUOP_SUB;
            m.result_src = RES_ALUOUT;
         end
         S_JAL: begin
            m.alu_src_a  = SRC_A_OLDPC;
            m.alu_src_b  = SRC_B_FOUR;
            m.alu_op     = ALUOP_ADD;
            m.result_src = RES_ALUOUT;
         end
         default: m = MOORE_IDLE;
      endcase
      return m;
   endfunction

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               width'(OP_LOAD),
               width'(OP_STORE):  state_d = S_MEMADR;
               width'(OP_RTYPE):  state_d = S_EXECUTER;
               width'(OP_ITYPE):  state_d = S_EXECUTEI;
               width'(OP_JAL):    state_d = S_JAL;
               width'(OP_BRANCH): state_d = S_BEQ;
               default:           state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (opcode == width'(OP_LOAD))
               state_d = S_MEMREAD;
            else if (opcode == width'(OP_STORE))
               state_d = S_MEMWRITE;
            else
               state_d = S_FETCH;
         end
         S_MEMREAD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
         S_BEQ:      state_d = S_FETCH;
         default:    state_d = S_FETCH;
      endcase
   end

   // Moore outputs are precomputed from the next state so they line up with state_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         moore_q <= moore_of(S_FETCH);
      end else begin
         state_q <= state_d;
         moore_q <= moore_of(state_d);
      end
   end

   assign moore_out   = rst ? MOORE_IDLE : moore_q;
   assign wait_access = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                        (state_q == S_MEMWRITE);

   assign bus.stall      = !rst && wait_access && !bus.mem_ready;
   assign bus.ir_write   = !rst && (state_q == S_FETCH) && bus.mem_ready;
   assign bus.pc_write   = !rst && (((state_q == S_FETCH) && bus.mem_ready) ||
                                    (state_q == S_JAL) ||
                                    ((state_q == S_BEQ) && bus.zero));
   assign bus.mem_read   = moore_out.mem_read;
   assign bus.mem_write  = moore_out.mem_write;
   assign bus.reg_write  = moore_out.reg_write;
   assign bus.adr_src    = moore_out.adr_src;
   assign bus.result_src = moore_out.result_src;
   assign bus.alu_src_a  = moore_out.alu_src_a;
   assign bus.alu_src_b  = moore_out.alu_src_b;
   assign bus.alu_op     = moore_out.alu_op;
   assign bus.imm_src    = imm_src;
   assign bus.state      = state_q;

endmodule
`default_nettype wire
